// File: rtl/fir_decim_pkg.sv
// Shared types and helpers for the FIR decimation / output-buffer stage.
package fir_decim_pkg;

  localparam int DEFAULT_DATA_W = 16;

  typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

  // Group sums need DECIM_LOG2 extra bits so a full group of extreme samples cannot wrap.
  function automatic int acc_width(input int data_w, input int decim_log2);
    return data_w + decim_log2;
  endfunction

endpackage

// File: rtl/decim_fifo.sv
// Show-ahead FIFO with a registered head, registered occupancy and a drop strobe for full pushes.
module decim_fifo
  import fir_decim_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [LW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic              valid_reg, full, do_pop, do_push;

  assign full       = (count_reg == LW'(DEPTH));
  assign do_pop     = pop && valid_reg;
  // A push into a full FIFO still lands when the same cycle frees a slot.
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)      count_next = count_reg + LW'(1);
    else if (do_pop && !do_push) count_next = count_reg - LW'(1);
  end

  always_comb begin
    head_next = head_reg;
    if (do_pop) begin
      if (count_reg > LW'(1)) head_next = mem[rd_ptr_inc];
      else if (do_push)       head_next = push_data;
    end else if (do_push && count_reg == '0) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      head_reg  <= head_next;
      valid_reg <= (count_next != '0);
    end
  end

  assign data_out  = head_reg;
  assign valid_out = valid_reg;
  assign level     = count_reg;

endmodule

// File: rtl/fir_decimator.sv
// Decimates the FIR sample stream by 2^DECIM_LOG2 and buffers results for a ready/valid consumer.
// Define FIR_DECIM_ACCUM_EN to average each group instead of keeping its last sample.
module fir_decimator
  import fir_decim_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DECIM_LOG2 = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);
  localparam int              PH_W       = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'((1 << DECIM_LOG2) - 1);

  logic [PH_W-1:0]   phase_reg;
  logic              group_done, push_v_reg, overflow_reg, drop;
  logic [DATA_W-1:0] group_res, push_d_reg;

  assign group_done = valid_in && (phase_reg == LAST_PHASE);

  // Phase only moves on valid samples, so input gaps do not change the grouping.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= '0;
    end else if (valid_in) begin
      phase_reg <= group_done ? '0 : phase_reg + PH_W'(1);
    end
  end

`ifdef FIR_DECIM_ACCUM_EN
  localparam int ACC_W = acc_width(DATA_W, DECIM_LOG2);

  logic signed [ACC_W-1:0] acc_reg, acc_base, group_sum;

  // Phase 0 starts a fresh sum rather than adding to the previous group.
  assign acc_base  = (phase_reg == '0) ? '0 : acc_reg;
  assign group_sum = acc_base + ACC_W'($signed(data_in));
  assign group_res = DATA_W'(group_sum >>> DECIM_LOG2);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (valid_in) begin
      acc_reg <= group_sum;
    end
  end
`else
  assign group_res = data_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      push_v_reg   <= 1'b0;
      push_d_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      push_v_reg <= group_done;
      if (group_done) push_d_reg <= group_res;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  decim_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_v_reg),
    .push_data (push_d_reg),
    .pop       (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .level     (level),
    .drop      (drop)
  );

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: three instances (D = 1, 2, 4) share one stimulus stream and are
// checked every cycle against a queue-level model, plus hand-computed output sequences.
module tb_fir_decimator;
  localparam int NI    = 3;
  localparam int DEPTH = 8;
  localparam int LW    = 4;
`ifdef FIR_DECIM_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0]   dout [NI];
  logic          vout [NI];
  logic [LW-1:0] lvl  [NI];
  logic          ovf  [NI];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_v1 = -1;

  int mq [NI][$];
  int lg [NI][$];
  bit pv [NI];
  int pd [NI];
  int gcnt [NI];
  int gsum [NI];
  bit ovm [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      fir_decimator #(
        .DATA_W     (16),
        .DECIM_LOG2 (gi),
        .FIFO_DEPTH (DEPTH)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (dout[gi]),
        .valid_out (vout[gi]),
        .ready_in  (ready_in),
        .level     (lvl[gi]),
        .overflow  (ovf[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: groups of 2^k valid samples -> one result, one cycle in a push stage, then a FIFO queue.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit pop_m;
      bit full_m;
      if (reset) begin
        mq[k].delete();
        pv[k] = 1'b0;
        gcnt[k] = 0;
        gsum[k] = 0;
        ovm[k] = 1'b0;
      end else begin
        pop_m  = (mq[k].size() > 0) && ready_in;
        full_m = (mq[k].size() == DEPTH);
        if (pop_m) void'(mq[k].pop_front());
        if (pv[k]) begin
          if (full_m && !pop_m) ovm[k] = 1'b1;
          else mq[k].push_back(pd[k]);
        end
        pv[k] = 1'b0;
        if (valid_in) begin
          gsum[k] += int'($signed(data_in));
          gcnt[k]++;
          if (gcnt[k] == (1 << k)) begin
            pv[k] = 1'b1;
            pd[k] = ACCUM ? (gsum[k] >>> k) : int'($signed(data_in));
            gcnt[k] = 0;
            gsum[k] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("valid_out[%0d]", k), int'(vout[k]), int'(mq[k].size() != 0));
      chk($sformatf("level[%0d]", k), int'(lvl[k]), mq[k].size());
      chk($sformatf("overflow[%0d]", k), int'(ovf[k]), int'(ovm[k]));
      if (vout[k] && mq[k].size() != 0)
        chk($sformatf("data_out[%0d]", k), int'($signed(dout[k])), mq[k][0]);
      if (vout[k] && ready_in) lg[k].push_back(int'($signed(dout[k])));
    end
    if (vout[1] && first_v1 < 0) first_v1 = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int v);
    valid_in = 1'b1;
    data_in  = 16'(v);
    step();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < NI; k++) lg[k].delete();
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s valid_out[%0d]", tag, k), int'(vout[k]), 0);
      chk($sformatf("%s data_out[%0d]", tag, k), int'(dout[k]), 0);
      chk($sformatf("%s level[%0d]", tag, k), int'(lvl[k]), 0);
      chk($sformatf("%s overflow[%0d]", tag, k), int'(ovf[k]), 0);
    end
  endtask

  task automatic check_log(input int k, input string name, input int exp[$]);
    chk({name, " count"}, lg[k].size(), exp.size());
    foreach (exp[i]) begin
      if (i < lg[k].size()) chk($sformatf("%s[%0d]", name, i), lg[k][i], exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e[$];
    int t2;
    t2 = 0;

    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("por");
    step();

    // D=2 contiguous 1..8, with first-output latency
    do_reset();
    ready_in = 1'b1;
    first_v1 = -1;
    for (int v = 1; v <= 8; v++) begin
      if (v == 2) t2 = cyc;
      send(v);
    end
    idle(8);
    chk("first valid_out latency", first_v1, t2 + 2);
`ifdef FIR_DECIM_ACCUM_EN
    e = '{1, 3, 5, 7};
`else
    e = '{2, 4, 6, 8};
`endif
    check_log(1, "d2_contig", e);

    // D=4 groups, including a negative group that floors
    do_reset();
    ready_in = 1'b1;
    send(4); send(8); send(12); send(16);
    send(-1); send(-1); send(-1); send(-2);
    idle(8);
`ifdef FIR_DECIM_ACCUM_EN
    e = '{10, -2};
`else
    e = '{16, -2};
`endif
    check_log(2, "d4_groups", e);

    // D=1 backpressure: 10 samples into 8 entries
    do_reset();
    ready_in = 1'b0;
    for (int v = 1; v <= 10; v++) send(v);
    idle(4);
    @(negedge clk);
    chk("bp level", int'(lvl[0]), 8);
    chk("bp overflow", int'(ovf[0]), 1);
    ready_in = 1'b1;
    idle(12);
    e.delete();
    for (int v = 1; v <= 8; v++) e.push_back(v);
    check_log(0, "bp_drain", e);
    @(negedge clk);
    chk("bp overflow sticky", int'(ovf[0]), 1);
    step();

    // D=1 full FIFO with push and pop landing on the same edge
    do_reset();
    ready_in = 1'b0;
    for (int v = 1; v <= 8; v++) send(v);
    idle(3);
    send(9);
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    @(negedge clk);
    chk("full push+pop level", int'(lvl[0]), 8);
    chk("full push+pop overflow", int'(ovf[0]), 0);
    e = '{1};
    check_log(0, "full_pop", e);
    step();
    ready_in = 1'b1;
    idle(12);
    e.delete();
    for (int v = 1; v <= 9; v++) e.push_back(v);
    check_log(0, "full_drain", e);

    // D=4 reset in the middle of a group
    do_reset();
    ready_in = 1'b1;
    send(1); send(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    for (int k = 0; k < NI; k++) lg[k].delete();
    step();
    send(5); send(6); send(7); send(8);
    idle(6);
`ifdef FIR_DECIM_ACCUM_EN
    e = '{6};
`else
    e = '{8};
`endif
    check_log(2, "midrst_out", e);

    // D=2 gapped input, one valid every third cycle
    do_reset();
    ready_in = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      send(v);
      idle(2);
    end
    idle(6);
`ifdef FIR_DECIM_ACCUM_EN
    e = '{1, 3, 5};
`else
    e = '{2, 4, 6};
`endif
    check_log(1, "d2_gapped", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
